// File: rtl/seq_rr_ctrl.sv
// ---------------------------------------------------------------------------
// seq_rr_ctrl
//   Round-robin controller sharing one external 4-state handshake sequencer
//   among N requesters. The sequencer has no reset of its own:
//     00 -X=0-> 01, 00 -X=1-> 00
//     01 -T=1-> 10, 01 -T=0-> 01
//     10 -> 11 -> 00 (unconditional)
//   The controller parks the sequencer in 00 (SYNC), arbitrates among
//   requesters (IDLE), launches a run (LAUNCH), holds the 01 dwell (DWELL),
//   advances it (FIRE), waits for it to return to 00 (DRAIN) and reports
//   completion (DONE). Any stall beyond TIMEOUT cycles, or leaving 01 early
//   during the dwell, aborts the run and re-parks the sequencer.
//
// Ports
//   clock      in   rising-edge clock
//   reset_n    in   synchronous active-low reset
//   req        in   N-bit level requests
//   seq_q1/q0  in   sequencer state bits
//   seq_x      out  sequencer X input (0 = launch), Moore decode of state
//   seq_t      out  sequencer T input (1 = advance from 01), Moore decode
//   gnt        out  one-hot grant, held from LAUNCH through DONE
//   done       out  one-cycle completion pulse (OK or error)
//   err        out  one-cycle error pulse, coincident with done
//   busy       out  high in every state except IDLE
//   dbg_state  out  current controller state, for debug/checkers
//
// Handshake: req is a level; a requester is served once per grant. gnt
// stays asserted for the whole run and drops the cycle after done (or
// together with done/err on an aborted run). Dropping req mid-run has no
// effect on the run in progress.
// ---------------------------------------------------------------------------
module seq_rr_ctrl #(
  parameter int N       = 4,
  parameter int DWELL   = 3,
  parameter int TIMEOUT = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         seq_q1,
  input  logic         seq_q0,
  output logic         seq_x,
  output logic         seq_t,
  output logic [N-1:0] gnt,
  output logic         done,
  output logic         err,
  output logic         busy,
  output logic [2:0]   dbg_state
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [2:0] {
    S_SYNC   = 3'd0,
    S_IDLE   = 3'd1,
    S_LAUNCH = 3'd2,
    S_DWELL  = 3'd3,
    S_FIRE   = 3'd4,
    S_DRAIN  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_idx;
  logic [TW-1:0] timer;
  logic [DW-1:0] dwell_cnt;

  logic [1:0]    seq_state;
  logic          timer_hit;
  logic          abort;
  logic [IW-1:0] next_ptr;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_onehot;
  int            cand;

  assign seq_state = {seq_q1, seq_q0};
  assign timer_hit = (timer == TW'(TIMEOUT - 1));
  assign next_ptr  = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
  assign dbg_state = state;

  // Sequencer inputs are pure decodes of the controller state.
  always_comb begin
    seq_x = 1'b1;
    seq_t = 1'b0;
    case (state)
      S_SYNC:   seq_t = 1'b1;
      S_LAUNCH: seq_x = 1'b0;
      S_FIRE:   seq_t = 1'b1;
      default:  ;
    endcase
  end

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    pick_found  = 1'b0;
    pick_idx    = '0;
    cand        = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
    pick_onehot           = '0;
    pick_onehot[pick_idx] = pick_found;
  end

  // A run is aborted when a waiting state stalls too long, or when the
  // sequencer leaves 01 while it should be dwelling there.
  always_comb begin
    abort = 1'b0;
    case (state)
      S_LAUNCH: abort = (seq_state != 2'b01) && timer_hit;
      S_DWELL:  abort = (seq_state != 2'b01);
      S_FIRE:   abort = (seq_state != 2'b10) && timer_hit;
      S_DRAIN:  abort = (seq_state != 2'b00) && timer_hit;
      default:  abort = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_SYNC;
      gnt       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b1;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      timer     <= '0;
      dwell_cnt <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort) begin
        state  <= S_SYNC;
        done   <= 1'b1;
        err    <= 1'b1;
        gnt    <= '0;
        rr_ptr <= next_ptr;
        timer  <= '0;
      end else begin
        case (state)
          S_SYNC: begin
            // Unknown or non-00 sequencer state keeps us driving T=1,
            // which walks 01/10/11 back to 00.
            if (seq_state == 2'b00) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              timer <= '0;
            end else if (timer_hit) begin
              done  <= 1'b1;
              err   <= 1'b1;
              timer <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          S_IDLE: begin
            if (pick_found) begin
              state   <= S_LAUNCH;
              busy    <= 1'b1;
              gnt     <= pick_onehot;
              gnt_idx <= pick_idx;
              timer   <= '0;
            end
          end
          S_LAUNCH: begin
            if (seq_state == 2'b01) begin
              state     <= S_DWELL;
              dwell_cnt <= '0;
              timer     <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          S_DWELL: begin
            if (dwell_cnt == DW'(DWELL - 1)) begin
              state <= S_FIRE;
              timer <= '0;
            end else begin
              dwell_cnt <= dwell_cnt + DW'(1);
            end
          end
          S_FIRE: begin
            if (seq_state == 2'b10) begin
              state <= S_DRAIN;
              timer <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          S_DRAIN: begin
            // Entered on 10, so 00 here means 11 has already been passed.
            if (seq_state == 2'b00) begin
              state  <= S_DONE;
              done   <= 1'b1;
              rr_ptr <= next_ptr;
              timer  <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            gnt   <= '0;
          end
          default: begin
            state <= S_SYNC;
            busy  <= 1'b1;
            gnt   <= '0;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule
